data_memory: RTL and testbench

Main-memory controller sitting directly downstream of the data cache. It accepts one word-wide read or write request at a time on the cache's memory side: a byte address, four data bytes and a write enable. It applies a configurable access latency, then performs the access on a byte-addressed internal array and returns four bytes with a one-cycle completion pulse. Bytes are big-endian: lane 0 holds the byte at the aligned address +0 (bits 31:24 of the cache word), and lane 3 holds +3.

---
 rtl/data_memory.sv | 135 +++++++++++++
 tb/tb_data_memory.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/data_memory.sv
// Word-access main-memory controller behind the data cache: fixed access latency, byte array, done pulse.
// Optional DATA_MEMORY_RANGE_CHECK_EN flags and suppresses accesses beyond MEM_BYTES.
module data_memory #(
    parameter int unsigned MEM_BYTES = 65536,
    parameter int unsigned LATENCY   = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req,
    input  logic       write_en,
    input  logic [31:0] address,
    input  logic [7:0] data_in  [0:3],
    output logic [7:0] data_out [0:3],
    output logic       busy,
    output logic       done,
    output logic       err
);

    localparam int unsigned AW = $clog2(MEM_BYTES);
    localparam int unsigned CW = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            accept_c;
    logic            commit_c;
    logic            oor_c;

    logic            we_q;
    logic [31:2]     addr_q;
    logic [7:0]      wdata_q [0:3];
    logic [AW-3:0]   base_c;

    logic [7:0]      mem [0:MEM_BYTES-1];

    // Word index inside the array; the aligned address wraps modulo MEM_BYTES.
    assign base_c = addr_q[AW-1:2];

`ifdef DATA_MEMORY_RANGE_CHECK_EN
    logic unused_c;
    assign oor_c    = |addr_q[31:AW];
    assign unused_c = ^address[1:0];
`else
    logic unused_c;
    assign oor_c    = 1'b0;
    assign unused_c = ^{address[1:0], addr_q[31:AW]};
`endif

    // Next-state and control decode.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        accept_c = 1'b0;
        commit_c = 1'b0;
        case (state_q)
            IDLE: begin
                if (req) begin
                    state_d  = WAIT;
                    cnt_d    = CW'(LATENCY - 1);
                    accept_c = 1'b1;
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d  = RESP;
                    commit_c = 1'b1;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Request capture; only the accepted values are used for the access.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            we_q   <= 1'b0;
            addr_q <= '0;
            for (int i = 0; i < 4; i++) wdata_q[i] <= 8'h00;
        end else if (accept_c) begin
            we_q   <= write_en;
            addr_q <= address[31:2];
            for (int i = 0; i < 4; i++) wdata_q[i] <= data_in[i];
        end
    end

    // Registered status outputs and read data.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy <= 1'b0;
            done <= 1'b0;
            err  <= 1'b0;
            for (int i = 0; i < 4; i++) data_out[i] <= 8'h00;
        end else begin
            busy <= (state_d != IDLE);
            done <= (state_d == RESP);
            err  <= commit_c & oor_c;
            if (commit_c && !we_q) begin
                for (int i = 0; i < 4; i++)
                    data_out[i] <= oor_c ? 8'h00 : mem[{base_c, 2'(i)}];
            end
        end
    end

    // Array is never cleared; reset only blocks commits by forcing IDLE.
    always_ff @(posedge clk) begin
        if (commit_c && we_q && !oor_c) begin
            for (int i = 0; i < 4; i++)
                mem[{base_c, 2'(i)}] <= wdata_q[i];
        end
    end

endmodule

// File: tb/tb_data_memory.sv
// Directed self-checking bench for data_memory (LATENCY=4 main instance, LATENCY=1 throughput instance).
module tb_data_memory;

    localparam int unsigned LAT  = 4;
    localparam int unsigned MEMB = 65536;
`ifdef DATA_MEMORY_RANGE_CHECK_EN
    localparam bit RC = 1'b1;
`else
    localparam bit RC = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic        req, write_en;
    logic [31:0] address;
    logic [7:0]  din  [0:3];
    logic [7:0]  dout [0:3];
    logic        busy, done, err;
    logic [31:0] rdata;

    logic        req_f, we_f;
    logic [31:0] addr_f;
    logic [7:0]  din_f  [0:3];
    logic [7:0]  dout_f [0:3];
    logic        busy_f, done_f, err_f;

    int n_checks = 0;
    int n_errors = 0;

    data_memory #(.MEM_BYTES(MEMB), .LATENCY(LAT)) u_dut (
        .clk(clk), .reset(reset), .req(req), .write_en(write_en), .address(address),
        .data_in(din), .data_out(dout), .busy(busy), .done(done), .err(err)
    );

    data_memory #(.MEM_BYTES(MEMB), .LATENCY(1)) u_fast (
        .clk(clk), .reset(reset), .req(req_f), .write_en(we_f), .address(addr_f),
        .data_in(din_f), .data_out(dout_f), .busy(busy_f), .done(done_f), .err(err_f)
    );

    assign rdata = {dout[0], dout[1], dout[2], dout[3]};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic set_req(input logic we, input logic [31:0] addr, input logic [31:0] wd);
        write_en = we;
        address  = addr;
        {din[0], din[1], din[2], din[3]} = wd;
    endtask

    // One full transaction: checks latency, busy during the wait, and the post-done idle cycle.
    task automatic xact(input string tag, input logic we, input logic [31:0] addr,
                        input logic [31:0] wd, output logic [31:0] rd, output logic e);
        int   lat;
        logic dropped;
        set_req(we, addr, wd);
        req = 1'b1;
        @(posedge clk); #1;
        req     = 1'b0;
        lat     = 0;
        dropped = 1'b0;
        while (done !== 1'b1 && lat < 64) begin
            if (busy !== 1'b1) dropped = 1'b1;
            @(posedge clk); #1;
            lat++;
        end
        check({tag, "_latency"}, 32'(lat), 32'(LAT));
        check({tag, "_busy_held"}, 32'(dropped), 32'd0);
        rd = rdata;
        e  = err;
        @(posedge clk); #1;
        check({tag, "_done_fall"}, 32'(done), 32'd0);
        check({tag, "_busy_fall"}, 32'(busy), 32'd0);
        check({tag, "_err_fall"}, 32'(err), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic        e;
        int          dones;
        int          lat;
        int          acc, dn, last_done, bad_gap;
        logic        prev_busy;

        reset = 1'b1;
        req = 1'b0; write_en = 1'b0; address = '0;
        req_f = 1'b0; we_f = 1'b0; addr_f = '0;
        for (int i = 0; i < 4; i++) begin din[i] = 8'h00; din_f[i] = 8'h00; end
        #2 reset = 1'b0;
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_data", rdata, 32'h0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;

        // Write then read back.
        xact("wr10", 1'b1, 32'h10, 32'hDEADBEEF, rd, e);
        check("wr10_err", 32'(e), 32'd0);
        check("wr10_data_unchanged", rd, 32'h0);
        xact("rd10", 1'b0, 32'h10, 32'h0, rd, e);
        check("rd10_data", rd, 32'hDEADBEEF);
        check("rd10_err", 32'(e), 32'd0);

        // Unaligned addresses collapse to the aligned word.
        xact("wr23", 1'b1, 32'h23, 32'h11223344, rd, e);
        check("wr23_hold", rd, 32'hDEADBEEF);
        xact("rd20", 1'b0, 32'h20, 32'h0, rd, e);
        check("rd20_data", rd, 32'h11223344);
        xact("rd21", 1'b0, 32'h21, 32'h0, rd, e);
        check("rd21_data", rd, 32'h11223344);

        // Inputs changed and req re-pulsed while busy.
        xact("wr84", 1'b1, 32'h84, 32'hA5A5A5A5, rd, e);
        set_req(1'b1, 32'h80, 32'h12345678);
        req = 1'b1;
        @(posedge clk); #1;
        req = 1'b0;
        set_req(1'b0, 32'h84, 32'hFFFFFFFF);
        dones = 0;
        for (int k = 0; k < 12; k++) begin
            if (k == 1) req = 1'b1;
            if (k == 2) req = 1'b0;
            @(posedge clk); #1;
            if (done === 1'b1) dones++;
        end
        check("midwait_done_count", 32'(dones), 32'd1);
        check("midwait_idle", 32'(busy), 32'd0);
        xact("rd80", 1'b0, 32'h80, 32'h0, rd, e);
        check("rd80_data", rd, 32'h12345678);
        xact("rd84", 1'b0, 32'h84, 32'h0, rd, e);
        check("rd84_data", rd, 32'hA5A5A5A5);

        // Reset two cycles into a write aborts it.
        xact("wr40", 1'b1, 32'h40, 32'h01020304, rd, e);
        set_req(1'b1, 32'h40, 32'hAABBCCDD);
        req = 1'b1;
        @(posedge clk); #1;
        req   = 1'b0;
        dones = 0;
        repeat (2) begin
            @(posedge clk); #1;
            if (done === 1'b1) dones++;
        end
        reset = 1'b0;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            if (done === 1'b1) dones++;
        end
        check("abort_no_done", 32'(dones), 32'd0);
        xact("rd40", 1'b0, 32'h40, 32'h0, rd, e);
        check("rd40_data", rd, 32'h01020304);

        // Reset during RESP: the write is already committed.
        set_req(1'b1, 32'h50, 32'hC0FFEE00);
        req = 1'b1;
        @(posedge clk); #1;
        req = 1'b0;
        lat = 0;
        while (done !== 1'b1 && lat < 64) begin
            @(posedge clk); #1;
            lat++;
        end
        check("resp_rst_latency", 32'(lat), 32'(LAT));
        reset = 1'b0;
        #1;
        check("resp_rst_done", 32'(done), 32'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        xact("rd50", 1'b0, 32'h50, 32'h0, rd, e);
        check("rd50_data", rd, 32'hC0FFEE00);

        // Address at and beyond the array end.
        xact("wr0", 1'b1, 32'h0, 32'hCAFEBABE, rd, e);
        xact("wr10000", 1'b1, 32'h10000, 32'h55667788, rd, e);
        check("wr10000_err", 32'(e), 32'(RC));
        xact("rd0", 1'b0, 32'h0, 32'h0, rd, e);
        check("rd0_data", rd, RC ? 32'hCAFEBABE : 32'h55667788);
        check("rd0_err", 32'(e), 32'd0);
        xact("rd10000", 1'b0, 32'h10000, 32'h0, rd, e);
        check("rd10000_data", rd, RC ? 32'h0 : 32'h55667788);
        check("rd10000_err", 32'(e), 32'(RC));

        // LATENCY=1 with req held: accept, RESP, one IDLE cycle, repeat.
        we_f   = 1'b1;
        addr_f = 32'h8;
        {din_f[0], din_f[1], din_f[2], din_f[3]} = 32'h9ABCDEF0;
        req_f     = 1'b1;
        prev_busy = busy_f;
        acc = 0; dn = 0; last_done = -1; bad_gap = 0;
        for (int k = 0; k < 35; k++) begin
            @(posedge clk); #1;
            if (busy_f === 1'b1 && prev_busy !== 1'b1) acc++;
            prev_busy = busy_f;
            if (done_f === 1'b1) begin
                dn++;
                if (last_done >= 0 && (k - last_done) != 3) bad_gap++;
                last_done = k;
            end
            if (k == 29) req_f = 1'b0;
        end
        check("fast_accepts", 32'(acc), 32'd10);
        check("fast_dones", 32'(dn), 32'd10);
        check("fast_done_spacing", 32'(bad_gap), 32'd0);
        check("fast_idle_end", 32'(busy_f), 32'd0);
        check("fast_err", 32'(err_f), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
